// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared AXI4 write-path definitions: burst-type and response
//                encodings, the write-slave FSM state type and the 4 KB
//                address-boundary constant.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    // AWBURST encodings (2'b11 is reserved)
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // BRESP encodings used by this slave
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // A burst may not cross an address boundary of 2**BOUNDARY_4K_LSB bytes
    localparam int unsigned BOUNDARY_4K_LSB = 12;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11,
//                seeded with 16'hACE1. Advances on every clock with en=1.
//  Ports       : clk, rst_n (async, active-low), en (advance), q (state)
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] q
);

    logic feedback;

    assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 16'hACE1;
        end else if (en) begin
            q <= {q[14:0], feedback};
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_wr_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axi_wr_slave_mem
//  Description : AXI4 write-channel slave that commits burst beats into an
//                on-chip SRAM write port. Bursts are checked at AW time
//                (burst type, size, address range, 4 KB crossing) and per
//                beat (WLAST placement); any violation yields SLVERR and sets
//                the sticky o_err flag. One burst outstanding at a time.
//  Ports       : clk, rst_n (async, active-low)
//                s_axi_aw* / s_axi_w* / s_axi_b* : AXI4 AW, W, B channels
//                mem_we/mem_addr/mem_wdata/mem_wstrb : SRAM write port,
//                  registered one cycle after the W handshake
//                o_burst_cnt : completed B handshakes (wraps)
//                o_err       : sticky, set when any SLVERR is handshaken
//  Options     : AXI_WR_SLAVE_BP_EN - LFSR-driven backpressure on WREADY and
//                a 0..3 cycle AWREADY delay; functionally transparent.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_slave_mem
    import axi_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned           MEM_DEPTH  = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_WIDTH-1:0]         s_axi_awaddr,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [2:0]                    s_axi_awsize,
    input  logic [1:0]                    s_axi_awburst,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [DATA_WIDTH-1:0]         s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]       s_axi_wstrb,
    input  logic                          s_axi_wlast,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    output logic                          mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic [DATA_WIDTH/8-1:0]       mem_wstrb,
    output logic [15:0]                   o_burst_cnt,
    output logic                          o_err
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned BYTE_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
    // Two guard bits so range arithmetic near the top of the map cannot wrap
    localparam int unsigned EXT_W    = ADDR_WIDTH + 2;

    wr_state_t state, state_nxt;

    logic                  run;        // low for the first cycle out of reset
    logic                  aw_gate;
    logic                  w_gate;
    logic                  aw_hs, w_hs, b_hs;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [7:0]            beat_cnt;
    logic                  aw_err_q;
    logic                  beat_err_q;
    logic                  last_beat;

    // ---------------- backpressure ----------------
`ifdef AXI_WR_SLAVE_BP_EN
    logic [15:0] lfsr_q;
    logic [1:0]  aw_wait;

    lfsr16 u_lfsr16 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .q     (lfsr_q)
    );

    // A fresh 0..3 cycle AWREADY delay is loaded while outside IDLE and
    // counts down once the FSM is back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 2'd0;
        end else if (state != WR_IDLE) begin
            aw_wait <= lfsr_q[5:4];
        end else if (aw_wait != 2'd0) begin
            aw_wait <= aw_wait - 2'd1;
        end
    end

    assign aw_gate = (aw_wait == 2'd0);
    assign w_gate  = (lfsr_q[2:0] > 3'd2);   // 3 of 8 codes stall
`else
    assign aw_gate = 1'b1;
    assign w_gate  = 1'b1;
`endif

    // ---------------- AW-time protocol checks ----------------
    logic [EXT_W-1:0] size_bytes, span, aw_lo, aw_start, aw_last, mem_lo, mem_hi;
    logic             aw_err;

    always_comb begin
        size_bytes = EXT_W'(1) << s_axi_awsize;
        aw_lo      = EXT_W'(s_axi_awaddr);
        aw_start   = aw_lo & ~(size_bytes - EXT_W'(1));
        if (s_axi_awburst == BURST_FIXED) begin
            span = size_bytes;
        end else begin
            span = (EXT_W'(s_axi_awlen) + EXT_W'(1)) << s_axi_awsize;
        end
        aw_last = aw_start + span - EXT_W'(1);
        mem_lo  = EXT_W'(BASE_ADDR);
        mem_hi  = mem_lo + EXT_W'(MEM_DEPTH * STRB_W);
        aw_err  = (s_axi_awburst == BURST_WRAP) || (s_axi_awburst == 2'b11)
               || (32'(s_axi_awsize) > BYTE_LSB)
               || (aw_lo < mem_lo) || (aw_last >= mem_hi)
               || (aw_start[EXT_W-1:BOUNDARY_4K_LSB] != aw_last[EXT_W-1:BOUNDARY_4K_LSB]);
    end

    // ---------------- FSM ----------------
    assign last_beat = (beat_cnt == len_q);
    assign aw_hs     = s_axi_awvalid && s_axi_awready;
    assign w_hs      = s_axi_wvalid && s_axi_wready;
    assign b_hs      = s_axi_bvalid && s_axi_bready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = RESP_OKAY;
        unique case (state)
            WR_IDLE: begin
                s_axi_awready = run && aw_gate;
                if (s_axi_awvalid && run && aw_gate) begin
                    state_nxt = WR_DATA;
                end
            end
            WR_DATA: begin
                s_axi_wready = w_gate;
                // Burst closes on WLAST or on the final counted beat
                if (s_axi_wvalid && w_gate && (s_axi_wlast || last_beat)) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = (aw_err_q || beat_err_q) ? RESP_SLVERR : RESP_OKAY;
                if (s_axi_bready) begin
                    state_nxt = WR_IDLE;
                end
            end
            default: state_nxt = WR_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            cur_addr    <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beat_cnt    <= '0;
            aw_err_q    <= 1'b0;
            beat_err_q  <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            o_burst_cnt <= '0;
            o_err       <= 1'b0;
        end else begin
            run    <= 1'b1;
            mem_we <= 1'b0;
            if (aw_hs) begin
                cur_addr   <= s_axi_awaddr;
                len_q      <= s_axi_awlen;
                size_q     <= s_axi_awsize;
                burst_q    <= s_axi_awburst;
                aw_err_q   <= aw_err;
                beat_err_q <= 1'b0;
                beat_cnt   <= '0;
            end
            if (w_hs) begin
                // Bursts rejected at AW are still drained, just never written
                mem_we    <= !aw_err_q;
                mem_addr  <= IDX_W'((cur_addr - BASE_ADDR) >> BYTE_LSB);
                mem_wdata <= s_axi_wdata;
                mem_wstrb <= s_axi_wstrb;
                beat_cnt  <= beat_cnt + 8'd1;
                if (burst_q == BURST_INCR) begin
                    cur_addr <= cur_addr + (ADDR_WIDTH'(1) << size_q);
                end
                // Early WLAST or missing WLAST on the final beat
                if (s_axi_wlast != last_beat) begin
                    beat_err_q <= 1'b1;
                end
            end
            if (b_hs) begin
                o_burst_cnt <= o_burst_cnt + 16'd1;
                if (s_axi_bresp == RESP_SLVERR) begin
                    o_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_wr_slave_mem
//  Description : Self-checking bench for axi_wr_slave_mem. A table of burst
//                records drives AW/W/B traffic; expected SRAM writes are
//                queued as beats are driven and compared as mem_we appears.
//                Hand-written sequences cover back-to-back bursts and reset
//                in the middle of a burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_wr_slave_mem;
    import axi_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [15:0] o_burst_cnt;
    logic        o_err;

    axi_wr_slave_mem dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awlen   (awlen),
        .s_axi_awsize  (awsize),
        .s_axi_awburst (awburst),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wlast   (wlast),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .o_burst_cnt   (o_burst_cnt),
        .o_err         (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  strb;
        int          wlast_at;   // beat index carrying WLAST; > len means never
        bit          aw_ok;      // burst passes the AW-time checks
        logic [1:0]  exp_resp;
        logic [31:0] tag;        // beat data = tag | beat index
    } vec_t;

    typedef struct {
        logic [9:0]  idx;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    vec_t        vecs[12];
    wr_t         exp_q[$];
    logic [31:0] shadow[1024];
    int          checks  = 0;
    int          passed  = 0;
    int          exp_cnt = 0;
    logic        exp_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // SRAM port monitor: scoreboard pop and shadow memory update
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) shadow[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL spurious_we: write to word %0d data 0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.idx));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
                check("wr_strb", 64'(mem_wstrb), 64'(e.strb));
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Called just after a negedge; returns just after the negedge preceding
    // the edge on which the selected signal is seen high.
    task automatic wait_high(input int sel, input string name);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            #1;
            if ((sel == 0 && awready) || (sel == 1 && wready) || (sel == 2 && bvalid)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            $display("FAIL %s_timeout: not asserted within 200 cycles, expected assertion", name);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
    endtask

    // stop_after >= 0 abandons the burst after that many beats (no B phase)
    task automatic run_burst(input vec_t v, input int stop_after);
        int          nbeats;
        int          d;
        logic [31:0] a;
        wr_t         e;
        nbeats = (v.wlast_at <= int'(v.len)) ? v.wlast_at + 1 : int'(v.len) + 1;
        @(negedge clk);
        awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst; awvalid = 1'b1;
        wait_high(0, "awready");
        @(posedge clk);
        #1 awvalid = 1'b0;
        a = v.addr;
        for (int i = 0; i < nbeats; i++) begin
            if (stop_after >= 0 && i == stop_after) return;
            @(negedge clk);
            wdata = v.tag | 32'(i); wstrb = v.strb; wlast = (i == v.wlast_at); wvalid = 1'b1;
            if (v.aw_ok) begin
                e.idx = 10'((a - BASE) >> 2); e.data = wdata; e.strb = v.strb;
                exp_q.push_back(e);
            end
            if (v.burst == BURST_INCR) a = a + (32'd1 << v.size);
            wait_high(1, "wready");
            @(posedge clk);
            #1 wvalid = 1'b0; wlast = 1'b0;
        end
        @(negedge clk);
        wait_high(2, "bvalid");
        d = $urandom_range(0, 3);
        for (int k = 0; k < d; k++) begin
            @(negedge clk);
            #1;
        end
        check("bvalid_hold", 64'(bvalid), 64'(1));
        check("bresp", 64'(bresp), 64'(v.exp_resp));
        bready = 1'b1;
        @(posedge clk);
        #1 bready = 1'b0;
        exp_cnt++;
        if (v.exp_resp == RESP_SLVERR) exp_err = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("burst_cnt", 64'(o_burst_cnt), 64'(exp_cnt));
        check("o_err", 64'(o_err), 64'(exp_err));
        check("pending_writes", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        vec_t b0, b1, rv;
        //          addr              len    size  burst        strb   wlast ok  resp         tag
        vecs[0]  = '{BASE,            8'd255, 3'd2, BURST_INCR,  4'hF,  255,  1, RESP_OKAY,   32'h0000_0000};
        vecs[1]  = '{BASE + 32'hF00,  8'd255, 3'd2, BURST_INCR,  4'hF,  255,  0, RESP_SLVERR, 32'h1100_0000};
        vecs[2]  = '{BASE,            8'd7,   3'd2, BURST_INCR,  4'hF,  3,    1, RESP_SLVERR, 32'h2200_0000};
        vecs[3]  = '{BASE + 32'h800,  8'd3,   3'd2, BURST_INCR,  4'hF,  3,    1, RESP_OKAY,   32'h3300_0000};
        vecs[4]  = '{BASE + 32'h10,   8'd3,   3'd2, BURST_FIXED, 4'h5,  3,    1, RESP_OKAY,   32'h4400_0000};
        vecs[5]  = '{BASE + 32'h20,   8'd3,   3'd2, BURST_WRAP,  4'hF,  3,    0, RESP_SLVERR, 32'h5500_0000};
        vecs[6]  = '{BASE + 32'h20,   8'd1,   3'd3, BURST_INCR,  4'hF,  1,    0, RESP_SLVERR, 32'h6600_0000};
        vecs[7]  = '{BASE + 32'h40,   8'd3,   3'd2, BURST_INCR,  4'hF,  300,  1, RESP_SLVERR, 32'h7700_0000};
        vecs[8]  = '{BASE - 32'h10,   8'd1,   3'd2, BURST_INCR,  4'hF,  1,    0, RESP_SLVERR, 32'h8800_0000};
        vecs[9]  = '{BASE + 32'hFF0,  8'd3,   3'd2, BURST_INCR,  4'hF,  3,    1, RESP_OKAY,   32'h9900_0000};
        vecs[10] = '{BASE + 32'h100,  8'd3,   3'd1, BURST_INCR,  4'h3,  3,    1, RESP_OKAY,   32'hAA00_0000};
        vecs[11] = '{BASE + 32'hFF0,  8'd4,   3'd2, BURST_INCR,  4'hF,  4,    0, RESP_SLVERR, 32'hAB00_0000};

        for (int i = 0; i < 1024; i++) shadow[i] = 32'h0;
        rst_n = 1'b0;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

        // Reset state
        #12;
        check("rst_awready", 64'(awready), 64'(0));
        check("rst_wready", 64'(wready), 64'(0));
        check("rst_bvalid", 64'(bvalid), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_burst_cnt", 64'(o_burst_cnt), 64'(0));
        check("rst_err", 64'(o_err), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("idle_awready", 64'(awready), 64'(1));
        check("idle_wready", 64'(wready), 64'(0));

        for (int i = 0; i < 12; i++) begin
            run_burst(vecs[i], -1);
            if (i == 0) check("word255", 64'(shadow[255]), 64'(255));
        end
        check("fixed_word4", 64'(shadow[4]), 64'(32'h4400_0003 & 32'h00FF_00FF));

        // Back-to-back 256-beat bursts from a fresh reset
        do_reset();
        b0 = '{BASE,           8'd255, 3'd2, BURST_INCR, 4'hF, 255, 1, RESP_OKAY, 32'hB000_0000};
        b1 = '{BASE + 32'h400, 8'd255, 3'd2, BURST_INCR, 4'hF, 255, 1, RESP_OKAY, 32'hB000_0100};
        run_burst(b0, -1);
        run_burst(b1, -1);
        for (int w = 0; w < 512; w++) check("b2b_word", 64'(shadow[w]), 64'(32'hB000_0000 + w));
        check("b2b_cnt", 64'(o_burst_cnt), 64'(2));

        // Reset in the middle of a 256-beat burst
        rv = '{BASE, 8'd255, 3'd2, BURST_INCR, 4'hF, 255, 1, RESP_OKAY, 32'hC000_0000};
        run_burst(rv, 100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_awready", 64'(awready), 64'(0));
        check("mid_wready", 64'(wready), 64'(0));
        check("mid_bvalid", 64'(bvalid), 64'(0));
        check("mid_bresp", 64'(bresp), 64'(0));
        check("mid_mem_we", 64'(mem_we), 64'(0));
        check("mid_mem_addr", 64'(mem_addr), 64'(0));
        check("mid_mem_wdata", 64'(mem_wdata), 64'(0));
        check("mid_mem_wstrb", 64'(mem_wstrb), 64'(0));
        check("mid_burst_cnt", 64'(o_burst_cnt), 64'(0));
        check("mid_err", 64'(o_err), 64'(0));
        check("mid_pending", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 check("post_rst_bvalid", 64'(bvalid), 64'(0));
        end
        run_burst(vecs[3], -1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_wr_slave_mem.md
Name: axi_wr_slave_mem

Overview:
- AXI4 write-channel slave: terminates the bursts issued by the DMA write master and commits each data beat into an on-chip SRAM port.
- Sits directly downstream of the DMA master engine's AW/W/B channels, replacing the external memory for on-chip capture and integration tests.
- Performs full protocol checks on every burst and reports violations through BRESP and a sticky error flag.
- Read channels are out of scope.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; 32 or 64 only.
- BASE_ADDR, 32'h1000_0000, first byte address decoded by this slave.
- MEM_DEPTH, 1024, SRAM depth in DATA_WIDTH words; power of 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- s_axi_awaddr  in  ADDR_WIDTH  burst start address
- s_axi_awlen  in  8  beats minus 1
- s_axi_awsize  in  3  log2 bytes per beat
- s_axi_awburst  in  2  burst type
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
- s_axi_wlast  in  1  last beat
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- mem_we  out  1  SRAM write enable
- mem_addr  out  $clog2(MEM_DEPTH)  SRAM word index
- mem_wdata  out  DATA_WIDTH  SRAM data
- mem_wstrb  out  DATA_WIDTH/8  SRAM byte enables
- o_burst_cnt  out  16  completed B handshakes, wraps
- o_err  out  1  sticky: any SLVERR issued

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE.
- Reset mid-burst: abandons the burst immediately; no B response is issued.
- FSM states:
  - IDLE: awready=1. On AW handshake, latch addr/len/size/burst, evaluate error conditions, clear beat counter, go to DATA. awready is 0 in every other state (one outstanding burst).
  - DATA: wready=1. On each W handshake, the beat is written if the burst is error-free. mem_we/mem_addr/mem_wdata/mem_wstrb are registered with 1-cycle latency after the handshake.
    - Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). addr low bits are ignored; strobes pass through unchanged.
    - Address advance per beat: INCR adds 1<<size; FIXED holds.
    - Burst ends on the wlast beat or on beat awlen+1, whichever comes first; then go to RESP.
  - RESP: bvalid=1, bresp held stable until bready, then go to IDLE. bvalid may coincide with the final mem_we.
- SLVERR (2'b10) conditions, evaluated at AW:
  - awburst is WRAP or reserved;
  - awsize > log2(DATA_WIDTH/8);
  - any byte of the burst lies outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*bytes);
  - burst crosses a 4 KB boundary.
  - Effect: all beats are accepted but none written (mem_we stays 0).
- SLVERR (2'b10) conditions, evaluated per beat:
  - wlast asserted before beat awlen+1;
  - wlast absent on beat awlen+1.
  - Effect: beats already accepted are kept.
- Otherwise bresp=OKAY (2'b00).
- o_burst_cnt increments on every B handshake. o_err is set on any B handshake with SLVERR and cleared only by reset.
- W beats arriving before the AW handshake are stalled (wready=0 in IDLE).

Optional Feature:
- Macro AXI_WR_SLAVE_BP_EN.
  - Defined: in DATA, wready is gated by a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) and is deasserted about 3/8 of cycles. awready in IDLE is delayed by 0–3 LFSR-chosen cycles. The master's valid/data must hold, and functional results are identical.
  - Undefined: wready=1 throughout DATA and awready=1 throughout IDLE (no throttling).

Decomposition:
- Shared package axi_pkg:
  - burst-type constants FIXED/INCR/WRAP;
  - resp constants OKAY/SLVERR;
  - wr_slave FSM state enum;
  - 4 KB boundary constant.
- One sub-module: lfsr16 (free-running, enable input), instantiated only under AXI_WR_SLAVE_BP_EN.

Test Plan:
- Single full burst: AW 0x1000_0000, len 255, size 2, INCR; data = beat index → words 0..255 hold 0..255, bresp 00, o_burst_cnt=1, o_err=0.
- 4 KB crossing: AW 0x1000_0F00, len 255 → 256 beats accepted, mem_we never asserts, bresp 10, o_err=1.
- Early wlast: len 7, wlast on beat 4 → words 0..3 written, bresp 10, FSM back in IDLE, next burst gives OKAY.
- Strobes and FIXED: burst FIXED at 0x1000_0010, len 3, wstrb 4'b0101 → only mem_addr 4 written, 4 times, mem_wstrb=0101 each beat.
- Back-to-back bursts with AXI_WR_SLAVE_BP_EN defined: two 256-beat INCR bursts at 0x1000_0000 and 0x1000_0400 under random bready → 512 words correct, o_burst_cnt=2.
- Reset mid-burst: rst_n low at beat 100 of 256 → all outputs 0 within the same cycle, no bvalid; after release, a new burst completes OKAY.
